// File: rtl/io16_display_arbiter.sv
// -----------------------------------------------------------------------------
// io16_display_arbiter
//
// Shares the 16-LED bank of the IO16 expander between three requesters
// (counter display, switch mirror, diagnostic pattern). Each requester uses a
// level REQ / registered GNT handshake. Grants rotate round-robin from a
// priority pointer that only advances when a grantee leaves, so the two other
// requesters are always ahead of the one that just released. A time slice,
// counted in TICK strobes, lets a waiting requester preempt a grantee that has
// held the bank for SLICE_TICKS strobes. Every change of owner passes through
// a one-cycle blanking state so the LEDs never show a mix of two owners.
//
// Parameters
//   SLICE_TICKS  TICK strobes a grantee may hold the bank while another
//                request is pending (1..65535).
//
// Ports
//   CLK    in   1   system clock, rising edge
//   RST    in   1   asynchronous active-high reset
//   TICK   in   1   single-cycle slice time-base strobe
//   REQ    in   3   level request, bit i = requester i
//   DATA0  in  16   LED word of requester 0 (bit 15 -> D1, bit 0 -> D16)
//   DATA1  in  16   LED word of requester 1
//   DATA2  in  16   LED word of requester 2
//   GNT    out  3   registered one-hot grant, 000 when nobody owns the bank
//   SEL    out  2   registered index of the current / last grantee
//   BUSY   out  1   registered, high while any GNT bit is high
//   D      out 16   registered LED word
// -----------------------------------------------------------------------------
module io16_display_arbiter #(
    parameter int unsigned SLICE_TICKS = 32'd1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        TICK,
    input  logic [2:0]  REQ,
    input  logic [15:0] DATA0,
    input  logic [15:0] DATA1,
    input  logic [15:0] DATA2,
    output logic [2:0]  GNT,
    output logic [1:0]  SEL,
    output logic        BUSY,
    output logic [15:0] D
);

    localparam logic [15:0] SLICE_C = 16'(SLICE_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    // Next index in the rotation 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] succ_idx(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    // One-hot grant vector for a requester index.
    function automatic logic [2:0] to_onehot(input logic [1:0] idx);
        logic [2:0] vec;
        case (idx)
            2'd0:    vec = 3'b001;
            2'd1:    vec = 3'b010;
            2'd2:    vec = 3'b100;
            default: vec = 3'b000;
        endcase
        return vec;
    endfunction

    // First high request bit scanning ptr, ptr+1, ptr+2 (mod 3).
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] pick;
        logic [1:0] cand;
        logic       found;
        pick  = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pick  = (!found && req[cand]) ? cand : pick;
            found = found | req[cand];
            cand  = succ_idx(cand);
        end
        return pick;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  sel_r;
    logic [1:0]  sel_nxt_s;
    logic [1:0]  ptr_r;
    logic [1:0]  ptr_nxt_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_nxt_s;
    logic [2:0]  gnt_r;
    logic [2:0]  gnt_nxt_s;
    logic        busy_r;
    logic [15:0] d_r;
    logic [15:0] d_nxt_s;
    logic [1:0]  win_s;
    logic [2:0]  own_mask_s;
    logic        other_req_s;
    logic        release_s;
    logic        slice_done_s;
    logic [15:0] grant_data_s;

    // Arbitration and slice qualifiers derived from the registered owner.
    always_comb begin
        win_s        = rr_pick(REQ, ptr_r);
        own_mask_s   = to_onehot(sel_r);
        other_req_s  = |(REQ & ~own_mask_s);
        release_s    = ~|(REQ & own_mask_s);
        slice_done_s = (cnt_r == SLICE_C);
    end

    // LED word of the current grantee.
    always_comb begin
        case (sel_r)
            2'd0:    grant_data_s = DATA0;
            2'd1:    grant_data_s = DATA1;
            2'd2:    grant_data_s = DATA2;
            default: grant_data_s = 16'h0000;
        endcase
    end

    // Next-state and next-output logic of the arbiter FSM.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        ptr_nxt_s   = ptr_r;
        cnt_nxt_s   = cnt_r;
        gnt_nxt_s   = 3'b000;
        d_nxt_s     = 16'h0000;
        case (state_r)
            ST_IDLE: begin
                if (|REQ) begin
                    state_nxt_s = ST_GRANT;
                    sel_nxt_s   = win_s;
                    cnt_nxt_s   = 16'd0;
                    gnt_nxt_s   = to_onehot(win_s);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                d_nxt_s = grant_data_s;
                // Saturating slice counter; its value is irrelevant once we leave.
                if (TICK && (cnt_r < SLICE_C)) begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                // Release takes precedence over preemption.
                if (release_s) begin
                    state_nxt_s = ST_SWITCH;
                end else if (slice_done_s && other_req_s) begin
                    state_nxt_s = ST_SWITCH;
                end else begin
                    state_nxt_s = ST_GRANT;
                    gnt_nxt_s   = own_mask_s;
                end
            end
            ST_SWITCH: begin
                // Blanking cycle; the leaver moves to the back of the rotation.
                ptr_nxt_s   = succ_idx(sel_r);
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = 3'b000;
            end
        endcase
    end

    // State, pointer, counter and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            sel_r   <= 2'd0;
            ptr_r   <= 2'd0;
            cnt_r   <= 16'd0;
            gnt_r   <= 3'b000;
            busy_r  <= 1'b0;
            d_r     <= 16'h0000;
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
            ptr_r   <= ptr_nxt_s;
            cnt_r   <= cnt_nxt_s;
            gnt_r   <= gnt_nxt_s;
            busy_r  <= |gnt_nxt_s;
            d_r     <= d_nxt_s;
        end
    end

    assign GNT  = gnt_r;
    assign SEL  = sel_r;
    assign BUSY = busy_r;
    assign D    = d_r;

endmodule

// File: tb/tb_io16_display_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for io16_display_arbiter (SLICE_TICKS = 4). Directed scenarios
// followed by a randomized phase; every cycle is compared with an
// owner/queue style reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_io16_display_arbiter;

    localparam int SLICE = 4;

    logic        CLK;
    logic        RST;
    logic        TICK;
    logic [2:0]  REQ;
    logic [15:0] DATA0;
    logic [15:0] DATA1;
    logic [15:0] DATA2;
    logic [2:0]  GNT;
    logic [1:0]  SEL;
    logic        BUSY;
    logic [15:0] D;

    int checks;
    int errors;

    // Reference model: who owns the bank, who owned it last, rotation start.
    int          m_owner;
    int          m_last;
    int          m_ptr;
    int          m_cnt;
    bit          m_blank;
    logic [15:0] m_d;

    io16_display_arbiter #(.SLICE_TICKS(SLICE)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .TICK  (TICK),
        .REQ   (REQ),
        .DATA0 (DATA0),
        .DATA1 (DATA1),
        .DATA2 (DATA2),
        .GNT   (GNT),
        .SEL   (SEL),
        .BUSY  (BUSY),
        .D     (D)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input int idx);
        if (idx == 0) return DATA0;
        else if (idx == 1) return DATA1;
        else return DATA2;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_blank = 1'b0;
        m_d     = 16'h0000;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int others;
        m_d = (m_owner >= 0) ? word_of(m_owner) : 16'h0000;
        if (m_owner >= 0) begin
            others = int'(REQ) & ~(1 << m_owner) & 7;
            if (REQ[m_owner] == 1'b0 || (m_cnt == SLICE && others != 0)) begin
                m_last  = m_owner;
                m_owner = -1;
                m_blank = 1'b1;
            end else if (TICK && m_cnt < SLICE) begin
                m_cnt++;
            end
        end else if (m_blank) begin
            m_ptr   = (m_last + 1) % 3;
            m_blank = 1'b0;
        end else if (REQ != 3'b000) begin
            for (int k = 0; k < 3; k++) begin
                if (m_owner < 0 && REQ[(m_ptr + k) % 3]) m_owner = (m_ptr + k) % 3;
            end
            m_last = m_owner;
            m_cnt  = 0;
        end
    endtask

    task automatic compare_all();
        chk("gnt",  32'(GNT),  (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("sel",  32'(SEL),  32'(m_last));
        chk("busy", 32'(BUSY), (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("d",    32'(D),    32'(m_d));
        chk("ptr",  32'(dut.ptr_r), 32'(m_ptr));
        if (m_owner >= 0) chk("cnt", 32'(dut.cnt_r), 32'(m_cnt));
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1; TICK = 1'b0; REQ = 3'b000;
        DATA0 = 16'h0000; DATA1 = 16'h0000; DATA2 = 16'h0000;
        model_reset();
        #12;
        chk("rst_gnt",  32'(GNT),  32'd0);
        chk("rst_sel",  32'(SEL),  32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_d",    32'(D),    32'd0);
        RST = 1'b0;

        // Single grant with live data update
        REQ = 3'b010; DATA1 = 16'hA5C3;
        step(); chk("single_gnt", 32'(GNT), 32'h2);
        step(); chk("single_d",   32'(D),   32'hA5C3);
        DATA1 = 16'h00FF;
        step(); chk("live_d",     32'(D),   32'h00FF);
        REQ = 3'b000;
        repeat (3) step();

        // Release and rotate: pointer is now 2, so 0 wins over 1
        REQ = 3'b011; DATA0 = 16'h1234;
        step(); chk("rot_first", 32'(GNT), 32'h1);
        step();
        REQ = 3'b010;
        step(); chk("rot_gap1_gnt", 32'(GNT), 32'h0);
        step(); chk("rot_gap2_gnt", 32'(GNT), 32'h0); chk("rot_gap2_d", 32'(D), 32'h0);
        step(); chk("rot_next", 32'(GNT), 32'h2);
        REQ = 3'b000;
        repeat (3) step();

        // Preemption after SLICE ticks with requester 2 pending
        REQ = 3'b001;
        step(); chk("pre_grant", 32'(GNT), 32'h1);
        REQ = 3'b101;
        for (int i = 0; i < SLICE; i++) begin
            TICK = 1'b1;
            step(); chk("pre_hold", 32'(GNT), 32'h1);
        end
        TICK = 1'b0;
        step(); chk("pre_switch", 32'(GNT), 32'h0);
        step();
        step(); chk("pre_new", 32'(GNT), 32'h4);
        REQ = 3'b111;
        repeat (2) step();
        REQ = 3'b011;
        repeat (5) step();
        REQ = 3'b000;
        repeat (4) step();

        // Lone requester is never preempted; counter saturates
        REQ = 3'b001;
        step();
        TICK = 1'b1;
        repeat (10) step();
        TICK = 1'b0;
        chk("alone_gnt", 32'(GNT), 32'h1);
        chk("alone_cnt", 32'(dut.cnt_r), 32'(SLICE));
        REQ = 3'b000;
        repeat (3) step();

        // Release coinciding with slice-completing tick; then withdrawal
        REQ = 3'b111;
        step();
        TICK = 1'b1;
        repeat (SLICE - 1) step();
        REQ = 3'b111 & ~3'(1 << m_owner);
        step(); chk("sim_switch", 32'(GNT), 32'h0);
        TICK = 1'b0;
        step();
        REQ = 3'b000;
        step(); chk("withdrawn", 32'(GNT), 32'h0);
        repeat (2) step();

        // Asynchronous reset in the middle of a grant
        REQ = 3'b100; DATA2 = 16'hBEEF;
        repeat (3) step();
        RST = 1'b1;
        #1;
        chk("async_gnt",  32'(GNT),  32'd0);
        chk("async_d",    32'(D),    32'd0);
        chk("async_busy", 32'(BUSY), 32'd0);
        chk("async_sel",  32'(SEL),  32'd0);
        model_reset();
        REQ = 3'b001;
        #2;
        RST = 1'b0;
        step(); chk("post_rst_gnt", 32'(GNT), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) REQ = 3'($urandom_range(0, 7));
            TICK  = ($urandom_range(0, 2) == 0);
            DATA0 = 16'($urandom);
            DATA1 = 16'($urandom);
            DATA2 = 16'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
